// File: rtl/pu_pkg.sv
// Shared definitions for the processing-unit datapath: element geometry defaults,
// round-count helpers and the operand sequencer state encoding.
package pu_pkg;

   localparam int PU_N_ELEM = 62;
   localparam int PU_ELEM_W = 8;
   localparam int PU_LANES  = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   // Number of LANES-wide rounds needed to cover n elements.
   function automatic int calc_rounds(input int n, input int l);
      return (n + l - 1) / l;
   endfunction

   // Round index width; a single-round neuron still needs a 1-bit counter.
   function automatic int calc_rnd_w(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

endpackage

// File: rtl/pu_operand_sequencer_if.sv
// Handshake and operand bus between the layer controller, the operand sequencer
// and the PU multiply-accumulate datapath.
interface pu_operand_sequencer_if
   import pu_pkg::*;
#(
   parameter int N_ELEM = PU_N_ELEM,
   parameter int ELEM_W = PU_ELEM_W,
   parameter int LANES  = PU_LANES
) ();

   localparam int ROUNDS = calc_rounds(N_ELEM, LANES);
   localparam int RND_W  = calc_rnd_w(ROUNDS);

   logic                      start;
   logic [N_ELEM*ELEM_W-1:0]  inputs_neuron;
   logic [N_ELEM*ELEM_W-1:0]  weights_neuron;
   logic                      out_ready;
   logic                      out_valid;
   logic [LANES*ELEM_W-1:0]   selected_inputs;
   logic [LANES*ELEM_W-1:0]   selected_weights;
   logic [RND_W-1:0]          round;
   logic                      last_round;
   logic [LANES-1:0]          lane_mask;
   logic                      busy;
   logic                      done;

   modport master (
      output start, inputs_neuron, weights_neuron, out_ready,
      input  out_valid, selected_inputs, selected_weights, round,
             last_round, lane_mask, busy, done
   );

   modport slave (
      input  start, inputs_neuron, weights_neuron, out_ready,
      output out_valid, selected_inputs, selected_weights, round,
             last_round, lane_mask, busy, done
   );

endinterface

// File: rtl/pu_operand_shifter.sv
// Loadable operand buffer: captures a neuron vector zero-padded to whole rounds and
// shifts one round of lanes out of its low end per advance.
module pu_operand_shifter
   import pu_pkg::*;
#(
   parameter int N_ELEM = PU_N_ELEM,
   parameter int ELEM_W = PU_ELEM_W,
   parameter int LANES  = PU_LANES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic                     shift,
   input  logic [N_ELEM*ELEM_W-1:0] din,
   output logic [LANES*ELEM_W-1:0]  dout
);

   localparam int ROUNDS = calc_rounds(N_ELEM, LANES);
   localparam int BUF_W  = ROUNDS * LANES * ELEM_W;
   localparam int RND_BW = LANES * ELEM_W;

   logic [BUF_W-1:0] buf_q;

   // The size cast zero-extends, so pad lanes of the final round read as zero;
   // shifting in zeros keeps drained lanes zero as well.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q <= '0;
      end else if (load) begin
         buf_q <= BUF_W'(din);
      end else if (shift) begin
         buf_q <= buf_q >> RND_BW;
      end
   end

   assign dout = buf_q[RND_BW-1:0];

endmodule

// File: rtl/pu_operand_sequencer.sv
// Captures a neuron's input and weight vectors on start and streams them to the PU
// LANES elements per round under a valid/ready handshake.
module pu_operand_sequencer
   import pu_pkg::*;
#(
   parameter int N_ELEM = PU_N_ELEM,
   parameter int ELEM_W = PU_ELEM_W,
   parameter int LANES  = PU_LANES
) (
   input  logic                   clk,
   input  logic                   rst,
   pu_operand_sequencer_if.slave  bus
);

   localparam int ROUNDS = calc_rounds(N_ELEM, LANES);
   localparam int RND_W  = calc_rnd_w(ROUNDS);
   localparam int N_LAST = N_ELEM - (ROUNDS - 1) * LANES;

   localparam logic [LANES-1:0] FULL_MASK = '1;
   localparam logic [LANES-1:0] LAST_MASK = FULL_MASK >> (LANES - N_LAST);
   localparam logic [RND_W-1:0] LAST_RND  = RND_W'(ROUNDS - 1);

   state_t           state, state_nxt;
   logic [RND_W-1:0] round_q;
   logic             done_q;
   logic             load;
   logic             advance;
   logic             finish;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            // out_valid is implied by STREAM, so ready alone completes the handshake.
            if (bus.out_ready) begin
               advance = 1'b1;
               if (round_q == LAST_RND) begin
                  finish    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Round index wraps to zero on the final handshake so IDLE always shows round 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= finish;
         if (load || finish) begin
            round_q <= '0;
         end else if (advance) begin
            round_q <= round_q + RND_W'(1);
         end
      end
   end

   pu_operand_shifter #(
      .N_ELEM (N_ELEM),
      .ELEM_W (ELEM_W),
      .LANES  (LANES)
   ) u_inputs (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (advance),
      .din   (bus.inputs_neuron),
      .dout  (bus.selected_inputs)
   );

   pu_operand_shifter #(
      .N_ELEM (N_ELEM),
      .ELEM_W (ELEM_W),
      .LANES  (LANES)
   ) u_weights (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (advance),
      .din   (bus.weights_neuron),
      .dout  (bus.selected_weights)
   );

   assign bus.out_valid  = (state == ST_STREAM);
   assign bus.busy       = (state == ST_STREAM);
   assign bus.done       = done_q;
   assign bus.round      = round_q;
   assign bus.last_round = (state == ST_STREAM) && (round_q == LAST_RND);
   assign bus.lane_mask  = (state != ST_STREAM) ? '0 :
                           (round_q == LAST_RND) ? LAST_MASK : FULL_MASK;

endmodule

// File: tb/tb_pu_operand_sequencer.sv
// Directed bench for pu_operand_sequencer: default 62/8/8 geometry plus the
// exact-multiple (16/8) and single-round (5/8) geometries.
module tb_pu_operand_sequencer;

   logic clk;
   logic rst;

   int vectors;
   int miscompares;

   pu_operand_sequencer_if #(.N_ELEM(62), .ELEM_W(8), .LANES(8)) bus_a ();
   pu_operand_sequencer_if #(.N_ELEM(16), .ELEM_W(8), .LANES(8)) bus_b ();
   pu_operand_sequencer_if #(.N_ELEM(5),  .ELEM_W(8), .LANES(8)) bus_c ();

   pu_operand_sequencer #(.N_ELEM(62), .ELEM_W(8), .LANES(8)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave));
   pu_operand_sequencer #(.N_ELEM(16), .ELEM_W(8), .LANES(8)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b.slave));
   pu_operand_sequencer #(.N_ELEM(5), .ELEM_W(8), .LANES(8)) dut_c (
      .clk (clk), .rst (rst), .bus (bus_c.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference lanes for the 62-element pattern: input e = e+1, weight e = 0x80|e.
   function automatic logic [63:0] model_in(input int r);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 8; k++)
         if (r * 8 + k < 62) v[k*8 +: 8] = 8'(r * 8 + k + 1);
      return v;
   endfunction

   function automatic logic [63:0] model_w(input int r);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 8; k++)
         if (r * 8 + k < 62) v[k*8 +: 8] = 8'(8'h80 | (r * 8 + k));
      return v;
   endfunction

   task automatic check_round_a(input string tag, input int r);
      check({tag, ".round"}, 64'(bus_a.round), 64'(r));
      check({tag, ".valid"}, 64'(bus_a.out_valid), 64'd1);
      check({tag, ".in"}, bus_a.selected_inputs, model_in(r));
      check({tag, ".w"}, bus_a.selected_weights, model_w(r));
      check({tag, ".mask"}, 64'(bus_a.lane_mask), (r == 7) ? 64'h3F : 64'hFF);
      check({tag, ".last"}, 64'(bus_a.last_round), (r == 7) ? 64'd1 : 64'd0);
   endtask

   task automatic load_pattern_a();
      for (int e = 0; e < 62; e++) begin
         bus_a.inputs_neuron[e*8 +: 8]  = 8'(e + 1);
         bus_a.weights_neuron[e*8 +: 8] = 8'(8'h80 | e);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      bus_a.start = 1'b0; bus_a.out_ready = 1'b0;
      bus_a.inputs_neuron = '0; bus_a.weights_neuron = '0;
      bus_b.start = 1'b0; bus_b.out_ready = 1'b1;
      bus_b.inputs_neuron = '0; bus_b.weights_neuron = '0;
      bus_c.start = 1'b0; bus_c.out_ready = 1'b1;
      bus_c.inputs_neuron = '0; bus_c.weights_neuron = '0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst.valid", 64'(bus_a.out_valid), 64'd0);
      check("rst.busy", 64'(bus_a.busy), 64'd0);
      check("rst.done", 64'(bus_a.done), 64'd0);
      check("rst.round", 64'(bus_a.round), 64'd0);
      check("rst.last", 64'(bus_a.last_round), 64'd0);
      check("rst.mask", 64'(bus_a.lane_mask), 64'd0);
      check("rst.in", bus_a.selected_inputs, 64'd0);
      check("rst.w", bus_a.selected_weights, 64'd0);

      // Neuron 1: full-rate stream; inputs overwritten after capture
      load_pattern_a();
      bus_a.out_ready = 1'b1;
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      bus_a.inputs_neuron = '1;
      check("n1.r0.in", bus_a.selected_inputs, 64'h0807060504030201);
      check("n1.r0.w", bus_a.selected_weights, 64'h8786858483828180);
      check("n1.r0.mask", 64'(bus_a.lane_mask), 64'hFF);
      check("n1.r0.busy", 64'(bus_a.busy), 64'd1);
      check_round_a("n1.r0", 0);
      for (int r = 1; r < 8; r++) begin
         tick();
         check_round_a("n1.rr", r);
         check("n1.nodone", 64'(bus_a.done), 64'd0);
      end
      check("n1.r7.in", bus_a.selected_inputs, 64'h00003E3D3C3B3A39);
      check("n1.r7.w", bus_a.selected_weights, 64'h0000BDBCBBBAB9B8);
      tick();
      check("n1.done", 64'(bus_a.done), 64'd1);
      check("n1.done.valid", 64'(bus_a.out_valid), 64'd0);
      check("n1.done.busy", 64'(bus_a.busy), 64'd0);
      check("n1.done.in", bus_a.selected_inputs, 64'd0);
      check("n1.done.mask", 64'(bus_a.lane_mask), 64'd0);
      tick();
      check("n1.done.pulse", 64'(bus_a.done), 64'd0);

      // Neuron 2: backpressure in round 2, ignored start in round 3
      load_pattern_a();
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check_round_a("n2.r0", 0);
      tick();
      check_round_a("n2.r1", 1);
      tick();
      check_round_a("n2.r2", 2);
      bus_a.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("n2.hold.in", bus_a.selected_inputs, 64'h1817161514131211);
         check("n2.hold.round", 64'(bus_a.round), 64'd2);
         check("n2.hold.valid", 64'(bus_a.out_valid), 64'd1);
         check("n2.hold.w", bus_a.selected_weights, model_w(2));
      end
      bus_a.out_ready = 1'b1;
      tick();
      check_round_a("n2.r3", 3);
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check_round_a("n2.r4", 4);
      for (int r = 5; r < 8; r++) begin
         tick();
         check_round_a("n2.rr", r);
      end
      tick();
      check("n2.done", 64'(bus_a.done), 64'd1);

      // Neuron 3: start coincident with done, then reset during round 4
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check_round_a("n3.r0", 0);
      for (int r = 1; r < 5; r++) begin
         tick();
         check_round_a("n3.rr", r);
      end
      rst = 1'b1;
      #1;
      check("n3.rst.valid", 64'(bus_a.out_valid), 64'd0);
      check("n3.rst.round", 64'(bus_a.round), 64'd0);
      check("n3.rst.in", bus_a.selected_inputs, 64'd0);
      check("n3.rst.w", bus_a.selected_weights, 64'd0);
      check("n3.rst.mask", 64'(bus_a.lane_mask), 64'd0);
      check("n3.rst.done", 64'(bus_a.done), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("n3.after.done", 64'(bus_a.done), 64'd0);
      check("n3.after.busy", 64'(bus_a.busy), 64'd0);

      // Neuron 4: fresh start after reset
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check_round_a("n4.r0", 0);

      // 16 elements / 8 lanes: two full rounds
      for (int e = 0; e < 16; e++) begin
         bus_b.inputs_neuron[e*8 +: 8]  = 8'(e + 1);
         bus_b.weights_neuron[e*8 +: 8] = 8'(8'h80 | e);
      end
      bus_b.start = 1'b1;
      tick();
      bus_b.start = 1'b0;
      check("b.r0.round", 64'(bus_b.round), 64'd0);
      check("b.r0.in", bus_b.selected_inputs, 64'h0807060504030201);
      check("b.r0.mask", 64'(bus_b.lane_mask), 64'hFF);
      check("b.r0.last", 64'(bus_b.last_round), 64'd0);
      tick();
      check("b.r1.round", 64'(bus_b.round), 64'd1);
      check("b.r1.in", bus_b.selected_inputs, 64'h100F0E0D0C0B0A09);
      check("b.r1.w", bus_b.selected_weights, 64'h8F8E8D8C8B8A8988);
      check("b.r1.mask", 64'(bus_b.lane_mask), 64'hFF);
      check("b.r1.last", 64'(bus_b.last_round), 64'd1);
      tick();
      check("b.done", 64'(bus_b.done), 64'd1);
      check("b.done.valid", 64'(bus_b.out_valid), 64'd0);

      // 5 elements / 8 lanes: single partial round
      for (int e = 0; e < 5; e++) begin
         bus_c.inputs_neuron[e*8 +: 8]  = 8'(e + 1);
         bus_c.weights_neuron[e*8 +: 8] = 8'(8'h80 | e);
      end
      bus_c.start = 1'b1;
      tick();
      bus_c.start = 1'b0;
      check("c.r0.valid", 64'(bus_c.out_valid), 64'd1);
      check("c.r0.in", bus_c.selected_inputs, 64'h0000000504030201);
      check("c.r0.w", bus_c.selected_weights, 64'h0000008483828180);
      check("c.r0.mask", 64'(bus_c.lane_mask), 64'h1F);
      check("c.r0.last", 64'(bus_c.last_round), 64'd1);
      tick();
      check("c.done", 64'(bus_c.done), 64'd1);
      check("c.done.last", 64'(bus_c.last_round), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
